// File: rtl/clock_div_bank.sv
// Bank of runtime-programmable integer clock dividers on one master clock.
// Divisor changes land on period boundaries; a global sync restarts all channels.
module clock_div_bank #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 8,
    parameter int INIT_DIV = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);
    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
    localparam logic [DIV_W-1:0] INIT_V   = DIV_W'(INIT_DIV);

    logic in_range;

    // Writes addressed past the last channel are dropped.
    assign in_range = ({1'b0, cfg_ch} < NUM_CH_W);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] cur_q, cur_d;
        logic [DIV_W-1:0] pnd_q, pnd_d;
        logic [DIV_W-1:0] half;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr, act, wrap;

        assign wr   = cfg_we && in_range && (cfg_ch == CH_W'(i));
        assign act  = (cur_q >= TWO);
        assign wrap = act && (cnt_q == cur_q - ONE);

        // Next counter/divisor; outputs derive from the next count so they stay registered.
        always_comb begin
            cnt_d  = cnt_q;
            cur_d  = cur_q;
            pnd_d  = pnd_q;
            pend_d = pend_q;
            if (sync) begin
                cnt_d  = '0;
                pend_d = 1'b0;
                if (wr) begin
                    cur_d = cfg_div;
                    pnd_d = cfg_div;
                end else if (pend_q) begin
                    cur_d = pnd_q;
                end
            end else begin
                if (wr) begin
                    pnd_d  = cfg_div;
                    pend_d = 1'b1;
                end
                if (!act || wrap) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        cur_d  = pnd_q;
                        pend_d = wr;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            half   = cur_d - (cur_d >> 1);
            clk_d  = !sync && (cur_d >= TWO) && (cnt_d >= half);
            tick_d = !sync && (cur_d >= TWO) && (cnt_d == half);
        end

        // Channel state register with synchronous reset.
        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt_q  <= '0;
                cur_q  <= INIT_V;
                pnd_q  <= INIT_V;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                cur_q  <= cur_d;
                pnd_q  <= pnd_d;
                pend_q <= pend_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank.
// Scenario tasks plus a randomized run against a behavioural model.
module tb_clock_div_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       sync = 1'b0;
    logic [3:0] clk_out, tick, pend;
    logic [2:0] clk3, tick3, pend3;

    int checks = 0;
    int errors = 0;

    int pos[4];
    int d[4];
    int pd[4];
    bit pv[4];

    always #5 clk = ~clk;

    clock_div_bank #(.NUM_CH(4), .DIV_W(8), .INIT_DIV(2)) dut (
        .clk_in(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    clock_div_bank #(.NUM_CH(3), .DIV_W(8), .INIT_DIV(2)) dut3 (
        .clk_in(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync),
        .clk_out(clk3), .tick(tick3), .pend(pend3)
    );

    function automatic void model_step(bit r, bit we, int ch, int dv, bit sy);
        for (int i = 0; i < 4; i++) begin
            bit wr;
            wr = we && (ch == i);
            if (r) begin
                pos[i] = 0; d[i] = 2; pd[i] = 2; pv[i] = 0;
            end else if (sy) begin
                if (wr) begin
                    d[i] = dv; pd[i] = dv;
                end else if (pv[i]) begin
                    d[i] = pd[i];
                end
                pv[i] = 0; pos[i] = 0;
            end else begin
                bit boundary;
                bit had;
                int old;
                boundary = (d[i] < 2) || (pos[i] == d[i] - 1);
                had = pv[i];
                old = pd[i];
                if (wr) begin
                    pd[i] = dv; pv[i] = 1;
                end
                if (boundary) begin
                    pos[i] = 0;
                    if (had) begin
                        d[i] = old; pv[i] = wr;
                    end
                end else begin
                    pos[i] = pos[i] + 1;
                end
            end
        end
    endfunction

    function automatic void model_out(output logic [3:0] c, output logic [3:0] t,
                                      output logic [3:0] p);
        c = '0; t = '0; p = '0;
        for (int i = 0; i < 4; i++) begin
            int h;
            h = (d[i] + 1) / 2;
            c[i] = (d[i] >= 2) && (pos[i] >= h);
            t[i] = (d[i] >= 2) && (pos[i] == h);
            p[i] = pv[i];
        end
    endfunction

    // Drive one clock worth of inputs, return at the following falling edge.
    task automatic cyc(input bit r, input bit we, input int ch, input int dv, input bit sy);
        rst = r; cfg_we = we; cfg_ch = 2'(ch); cfg_div = 8'(dv); sync = sy;
        @(posedge clk);
        model_step(r, we, ch, dv, sy);
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; sync = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || pend !== 4'h0) begin
            errors++;
            $display("FAIL reset: clk=%h tick=%h pend=%h required 0/0/0", clk_out, tick, pend);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0, 0);
            e = (k % 2) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== e || tick !== e || pend !== 4'h0 || clk3 !== e[2:0]) begin
                errors++;
                $display("FAIL div2 k=%0d: clk=%h tick=%h pend=%h clk3=%h required %h/%h/0",
                         k, clk_out, tick, pend, clk3, e, e);
            end
        end
    endtask

    task automatic test_program();
        int dv[4];
        logic [3:0] ec, et;
        dv = '{2, 5, 28, 16};
        cyc(0, 1, 1, 5, 0);
        cyc(0, 1, 2, 28, 0);
        cyc(0, 1, 3, 16, 0);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (clk_out !== 4'h0 || tick !== 4'h0 || pend !== 4'h0) begin
            errors++;
            $display("FAIL sync_clear: clk=%h tick=%h pend=%h required 0", clk_out, tick, pend);
        end
        for (int k = 1; k <= 60; k++) begin
            cyc(0, 0, 0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                ec[i] = (k % dv[i]) >= (dv[i] + 1) / 2;
                et[i] = (k % dv[i]) == (dv[i] + 1) / 2;
            end
            checks++;
            if (clk_out !== ec || tick !== et) begin
                errors++;
                $display("FAIL program k=%0d: clk=%h tick=%h required %h/%h",
                         k, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_glitch_free();
        logic ec, ep;
        cyc(0, 1, 0, 8, 1);
        for (int k = 1; k <= 22; k++) begin
            cyc(0, k == 3, 0, 3, 0);
            ec = (k < 8) ? (k >= 4) : (((k - 8) % 3) >= 2);
            ep = (k >= 3) && (k <= 7);
            checks++;
            if (clk_out[0] !== ec || pend[0] !== ep) begin
                errors++;
                $display("FAIL glitch k=%0d: clk0=%b pend0=%b required %b/%b",
                         k, clk_out[0], pend[0], ec, ep);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dd, pp, dv;
        bit we;
        logic ec, et, ep;
        cyc(0, 1, 1, 5, 1);
        for (int k = 1; k <= 46; k++) begin
            we = (k == 1) || (k == 2) || (k == 18) || (k == 36);
            dv = (k == 1) ? 6 : (k == 2) ? 10 : (k == 18) ? 1 : 4;
            cyc(0, we, 1, dv, 0);
            if (k < 5) begin
                dd = 5; pp = k; ep = 1'b1;
            end else if (k < 25) begin
                dd = 10; pp = (k - 5) % 10; ep = (k >= 18);
            end else if (k < 37) begin
                dd = 1; pp = 0; ep = (k == 36);
            end else begin
                dd = 4; pp = (k - 37) % 4; ep = 1'b0;
            end
            ec = (dd >= 2) && (pp >= (dd + 1) / 2);
            et = (dd >= 2) && (pp == (dd + 1) / 2);
            checks++;
            if (clk_out[1] !== ec || tick[1] !== et || pend[1] !== ep) begin
                errors++;
                $display("FAIL b2b k=%0d: clk1=%b tick1=%b pend1=%b required %b/%b/%b",
                         k, clk_out[1], tick[1], pend[1], ec, et, ep);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e;
        cyc(0, 1, 2, 7, 1);
        checks++;
        if (pend[2] !== 1'b0 || clk_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_we: pend2=%b clk2=%b required 0/0", pend[2], clk_out[2]);
        end
        for (int k = 1; k <= 14; k++) begin
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (clk_out[2] !== ((k % 7) >= 4) || pend[2] !== 1'b0) begin
                errors++;
                $display("FAIL sync_we_d7 k=%0d: clk2=%b pend2=%b required %b/0",
                         k, clk_out[2], pend[2], (k % 7) >= 4);
            end
        end
        cyc(0, 1, 3, 9, 0);
        checks++;
        if (pend !== 4'b1000 || pend3 !== 3'b000) begin
            errors++;
            $display("FAIL pend_oob: pend=%h pend3=%h required 8/0", pend, pend3);
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (pend !== 4'h0 || clk_out !== 4'h0 || tick !== 4'h0) begin
            errors++;
            $display("FAIL rst_pend: pend=%h clk=%h tick=%h required 0", pend, clk_out, tick);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc(0, 0, 0, 0, 0);
            e = (k % 2) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== e || pend !== 4'h0) begin
                errors++;
                $display("FAIL rst_div2 k=%0d: clk=%h pend=%h required %h/0", k, clk_out, pend, e);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] ec, et, ep;
        bit r, we, sy;
        int ch, dv;
        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            we = ($urandom_range(0, 3) == 0);
            sy = ($urandom_range(0, 31) == 0);
            ch = $urandom_range(0, 3);
            dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
            cyc(r, we, ch, dv, sy);
            model_out(ec, et, ep);
            checks++;
            if (clk_out !== ec || tick !== et || pend !== ep) begin
                errors++;
                $display("FAIL random n=%0d: clk=%h tick=%h pend=%h required %h/%h/%h",
                         n, clk_out, tick, pend, ec, et, ep);
            end
            checks++;
            if (clk3 !== ec[2:0] || tick3 !== et[2:0] || pend3 !== ep[2:0]) begin
                errors++;
                $display("FAIL random3 n=%0d: clk=%h tick=%h pend=%h required %h/%h/%h",
                         n, clk3, tick3, pend3, ec[2:0], et[2:0], ep[2:0]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0; d[i] = 2; pd[i] = 2; pv[i] = 0;
        end
        @(negedge clk);
        test_reset();
        test_program();
        test_glitch_free();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_div_bank.md
Name: clock_div_bank

Overview:
- Parametrised bank of NUM_CH independent integer clock dividers, each driven from one fast clock.
- Each channel has a divisor that is programmable at runtime and takes effect glitch-free, plus a registered divided-clock output and a one-cycle rising-edge strobe.
- A global sync input phase-aligns all channels.
- Sits between the board clock and downstream logic; generalises the fixed div-2/4/8/16/28/5 generator.

Parameters:
- NUM_CH, 4, number of divider channels (1..16)
- DIV_W, 8, width of each divisor and counter
- INIT_DIV, 2, divisor loaded into every channel on reset (must be >= 2 and < 2^DIV_W)

Ports:
- clk_in  input  1  master clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- cfg_we  input  1  write strobe for a divisor update
- cfg_ch  input  $clog2(NUM_CH) (min 1)  channel selected by cfg_we
- cfg_div  input  DIV_W  new divisor; a value < 2 means disable
- sync  input  1  one-cycle pulse; restarts all channels in phase
- clk_out  output  NUM_CH  divided clocks, registered
- tick  output  NUM_CH  one-cycle pulse in the first cycle clk_out[i] is high
- pend  output  NUM_CH  1 while channel i holds an unapplied divisor

Behaviour:
- Per-channel state: cnt[DIV_W], div_cur[DIV_W], div_pend[DIV_W], pend, clk_out, tick. All are registers; outputs have no combinational path from inputs.
- Reset (rst=1 at a clock edge, regardless of any other input):
  - cnt=0, div_cur=INIT_DIV, div_pend=INIT_DIV, pend=0, clk_out=0, tick=0.
  - Reset mid-operation aborts any period in progress and discards pending writes.
- Channel state:
  - ACTIVE when div_cur >= 2; DISABLED otherwise.
  - DISABLED: cnt=0, clk_out=0, tick=0.
- Let H = D - (D>>1), i.e. ceil(D/2).
- ACTIVE counting:
  - next cnt = (cnt == div_cur-1) ? 0 : cnt+1.
  - clk_out is registered alongside cnt and equals 1 exactly in cycles where cnt >= H.
  - So the low phase is H cycles and the high phase is D>>1 cycles. D=5 gives 3 low / 2 high; D=4 gives 2/2; D=2 gives 1/1.
  - tick = 1 exactly in cycles where cnt == H.
  - Period = div_cur clk_in cycles.
- First period after reset: cnt=0, so clk_out[i] first rises in the cycle when cnt==H, i.e. H clock edges after rst deasserts.
- Divisor write (cfg_we=1, rst=0):
  - div_pend[cfg_ch] <= cfg_div and pend[cfg_ch] <= 1.
  - A later write before application overwrites div_pend (last write wins).
  - cfg_ch >= NUM_CH: write ignored.
- Application, ACTIVE channel:
  - Applied only at the wrap edge (cnt == div_cur-1): div_cur <= div_pend, cnt <= 0, pend <= 0.
  - The current period always completes at the old divisor, so there are no runt pulses.
  - A write on the wrap cycle itself is applied at the next wrap, not the current one.
- Application, DISABLED channel: the pending divisor is applied on the edge after the write (pend high for exactly one cycle).
- Disabling: writing 0 or 1 to an ACTIVE channel lets the current period finish, then the channel goes DISABLED with clk_out=0.
- sync=1 (rst=0): for every channel, on the same edge:
  - If pend is set, div_cur <= div_pend and pend <= 0.
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Channels with equal divisors are then phase-identical.
- sync with a simultaneous cfg_we: the written value bypasses pending and is loaded directly into div_cur of cfg_ch; pend stays 0.
- Counter width: div_cur up to 2^DIV_W-1 is legal. cnt never exceeds div_cur-1 and never overflows.

Test Plan:
- Reset, 10 ns clk_in, INIT_DIV=2, NUM_CH=4: assert rst for 2 edges, release. Required: all clk_out toggle every cycle (period 20 ns), tick high every 2nd cycle, pend=0.
- Write ch1=5, ch2=28, ch3=16, then sync. Required:
  - clk_out[1] is 3 low / 2 high, period 50 ns.
  - clk_out[2] is 14/14, period 280 ns.
  - clk_out[3] is 8/8.
  - All first rising edges occur at H cycles after sync.
- Glitch-free change: ch0 at D=8, write D=3 when cnt=2. Required: pend[0]=1 until the wrap; the remaining old period is still 4 low / 4 high; then 2 low / 1 high; no high pulse shorter than its nominal phase.
- Back-to-back writes ch1: 6 then 10 before the wrap. Required: only 10 is applied; pend clears at the wrap. Write 1 to ch1: channel finishes its period, then clk_out[1]=0 and tick[1]=0 permanently; writing 4 re-enables it one cycle later.
- Simultaneous events:
  - sync and cfg_we(ch2=7) on the same edge: div_cur[2]=7 immediately, pend[2]=0.
  - rst during a pending write: pend=0, div_cur=INIT_DIV.
  - cfg_ch=NUM_CH: no state change.
